adc_frame_packer: RTL

ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

---
 rtl/adc_frame_packer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - ADC FIFO to UART frame packer; checksum byte enabled by FRAMER_CKSUM_EN
module adc_frame_packer #(
  parameter int         PAYLOAD_MAX  = 64,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         IDLE_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  fifoData,
  input  logic        fifoDataValid,
  input  logic        fifoNotEmpty,
  output logic        fifoRead,
  output logic [7:0]  txData,
  output logic        txWr,
  input  logic        txBusy,
  input  logic        enable,
  output logic        busy,
  output logic [15:0] frameCount
);

  localparam int            TW       = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]    PAY_LAST = 8'(PAYLOAD_MAX - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_FETCH,
    ST_WAITD,
    ST_SEND,
    ST_COUNT,
`ifdef FRAMER_CKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [7:0]     seq_q;
  logic [7:0]     pay_cnt_q;
  logic [7:0]     data_q;
  logic [1:0]     gap_q;
  logic [TW-1:0]  idle_cnt_q;
  logic           tx_wr_q;
  logic [7:0]     tx_data_q;
  logic [15:0]    frame_cnt_q;
  logic           tx_ok;
  logic           emit;
  logic [7:0]     emit_byte;
  logic           fifo_rd;
`ifdef FRAMER_CKSUM_EN
  logic [7:0]     cksum_q;
`endif

  assign fifoRead   = fifo_rd;
  assign txWr       = tx_wr_q;
  assign txData     = tx_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign frameCount = frame_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, byte emission and FIFO read strobe
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_byte = 8'h00;
    fifo_rd   = 1'b0;
    // A byte may go out only after the previous strobe has dropped and a
    // further settle cycle has passed, so txBusy is never sampled stale.
    tx_ok     = !txBusy && !tx_wr_q && (gap_q == 2'd0);
    case (state_q)
      ST_IDLE: begin
        if (enable && fifoNotEmpty) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (tx_ok) begin
          emit      = 1'b1;
          emit_byte = SYNC_BYTE;
          state_d   = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (tx_ok) begin
          emit      = 1'b1;
          emit_byte = seq_q;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fifoNotEmpty) begin
          fifo_rd = 1'b1;
          state_d = ST_WAITD;
        end else if ((idle_cnt_q == TO_LAST) && (pay_cnt_q != 8'd0)) begin
          state_d = ST_COUNT;
        end
      end
      ST_WAITD: begin
        if (fifoDataValid) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ok) begin
          emit      = 1'b1;
          emit_byte = data_q;
          state_d   = (pay_cnt_q == PAY_LAST) ? ST_COUNT : ST_FETCH;
        end
      end
      ST_COUNT: begin
        if (tx_ok) begin
          emit      = 1'b1;
          emit_byte = pay_cnt_q;
`ifdef FRAMER_CKSUM_EN
          state_d   = ST_CKSUM;
`else
          state_d   = ST_DONE;
`endif
        end
      end
`ifdef FRAMER_CKSUM_EN
      ST_CKSUM: begin
        if (tx_ok) begin
          emit      = 1'b1;
          emit_byte = cksum_q;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: tx strobe/data, payload count, captured byte, idle timer, SEQ and frame counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq_q       <= 8'd0;
      pay_cnt_q   <= 8'd0;
      data_q      <= 8'd0;
      gap_q       <= 2'd0;
      idle_cnt_q  <= '0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= 8'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      tx_wr_q <= emit;
      if (emit) begin
        tx_data_q <= emit_byte;
        gap_q     <= 2'd2;
      end else if (gap_q != 2'd0) begin
        gap_q <= gap_q - 2'd1;
      end

      if (state_q == ST_IDLE) begin
        pay_cnt_q <= 8'd0;
      end else if (emit && (state_q == ST_SEND)) begin
        pay_cnt_q <= pay_cnt_q + 8'd1;
      end

      if ((state_q == ST_WAITD) && fifoDataValid) data_q <= fifoData;

      // Count consecutive empty cycles while waiting for the next payload byte
      if ((state_q == ST_FETCH) && !fifoNotEmpty) begin
        if (idle_cnt_q != TO_LAST) idle_cnt_q <= idle_cnt_q + 1'b1;
      end else begin
        idle_cnt_q <= '0;
      end

      if (state_q == ST_DONE) begin
        seq_q       <= seq_q + 8'd1;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

`ifdef FRAMER_CKSUM_EN
  // Running XOR of SEQ, payload bytes and COUNT; SEQ emission restarts it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cksum_q <= 8'd0;
    end else if (emit) begin
      case (state_q)
        ST_SEQ:            cksum_q <= seq_q;
        ST_SEND, ST_COUNT: cksum_q <= cksum_q ^ emit_byte;
        default: ;
      endcase
    end
  end
`endif

endmodule
